// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative MIPS divider: state encoding and operand width.
package div_iter_pkg;

   localparam int unsigned DIV_WIDTH = 32;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

endpackage : div_iter_pkg

// File: rtl/div_iter.sv
// Radix-2 restoring divider for the EX stage: LO = quotient, HI = remainder,
// one quotient bit per cycle, with pipeline stall, annul and external-hold handling.
module div_iter
   import div_iter_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               signed_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               annul_i,
   input  logic               stall_ext_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o,
   output logic               stall_o
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   div_state_e       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;
   logic             is_signed;
   logic             sign_dvd;
   logic             sign_diff;

   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] rem_nx;
   logic [WIDTH-1:0] quo_nx;
   logic [WIDTH-1:0] quo_fix;
   logic [WIDTH-1:0] rem_fix;
   logic             q_bit;

   function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
      return (~x) + WIDTH'(1);
   endfunction

   function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x, input logic en);
      return (en && x[WIDTH-1]) ? negate(x) : x;
   endfunction

   // One restoring step; the dividend register shifts out dividend bits and shifts in quotient bits.
   always_comb begin
      rem_sh  = {rem, dvd[WIDTH-1]};
      q_bit   = (rem_sh >= {1'b0, dvs});
      rem_nx  = q_bit ? WIDTH'(rem_sh - {1'b0, dvs}) : rem_sh[WIDTH-1:0];
      quo_nx  = {dvd[WIDTH-2:0], q_bit};
      quo_fix = (is_signed && sign_diff) ? negate(quo_nx) : quo_nx;
      rem_fix = (is_signed && sign_dvd)  ? negate(rem_nx) : rem_nx;
   end

   // Gated by reset so the hazard unit sees no stall while the divider is held in reset.
   assign stall_o = rst && !annul_i &&
                    (((state == DIV_IDLE) && start_i) || (state == DIV_BUSY));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= DIV_IDLE;
         cnt       <= '0;
         rem       <= '0;
         dvd       <= '0;
         dvs       <= '0;
         is_signed <= 1'b0;
         sign_dvd  <= 1'b0;
         sign_diff <= 1'b0;
         result_o  <= '0;
         ready_o   <= 1'b0;
      end else begin
         case (state)
            DIV_IDLE: begin
               if (start_i && !annul_i) begin
                  is_signed <= signed_i;
                  sign_dvd  <= opdata1_i[WIDTH-1];
                  sign_diff <= opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1];
                  dvd       <= abs_val(opdata1_i, signed_i);
                  dvs       <= abs_val(opdata2_i, signed_i);
                  rem       <= '0;
                  cnt       <= '0;
                  if (opdata2_i == '0) begin
                     state    <= DIV_DONE;
                     ready_o  <= 1'b1;
                     result_o <= {opdata1_i, {WIDTH{1'b1}}};
                  end else begin
                     state <= DIV_BUSY;
                  end
               end
            end
            DIV_BUSY: begin
               if (annul_i) begin
                  state <= DIV_IDLE;
               end else begin
                  rem <= rem_nx;
                  dvd <= quo_nx;
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == CNT_W'(WIDTH - 1)) begin
                     state    <= DIV_DONE;
                     ready_o  <= 1'b1;
                     result_o <= {rem_fix, quo_fix};
                  end
               end
            end
            DIV_DONE: begin
               if (annul_i || !stall_ext_i) begin
                  state   <= DIV_IDLE;
                  ready_o <= 1'b0;
               end
            end
            default: begin
               state   <= DIV_IDLE;
               ready_o <= 1'b0;
            end
         endcase
      end
   end

endmodule : div_iter

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed MIPS DIV/DIVU cases, control scenarios,
// and random operands against a 64-bit arithmetic reference model.
module tb_div_iter;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic        signed_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        annul_i;
   logic        stall_ext_i;
   logic [63:0] result_o;
   logic        ready_o;
   logic        stall_o;

   int checks = 0;
   int passed = 0;

   div_iter dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start_i),
      .signed_i    (signed_i),
      .opdata1_i   (opdata1_i),
      .opdata2_i   (opdata2_i),
      .annul_i     (annul_i),
      .stall_ext_i (stall_ext_i),
      .result_o    (result_o),
      .ready_o     (ready_o),
      .stall_o     (stall_o)
   );

   always #5 clk = ~clk;

   // MIPS semantics: truncating division, remainder takes the dividend sign, /0 gives {dividend, all-ones}.
   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
      longint sa, sb, q, r;
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   // Issues one request and waits for ready_o; returns in the DONE cycle, 1 time unit after the falling edge.
   task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          output logic [63:0] res, output int lat, output int nstall,
                          output logic done_stall);
      @(negedge clk);
      start_i = 1'b1; signed_i = sgn; opdata1_i = a; opdata2_i = b;
      #1;
      nstall = int'(stall_o);
      lat = -1; res = '0; done_stall = 1'bx;
      @(negedge clk);
      start_i = 1'b0;
      for (int k = 1; k <= 200; k++) begin
         if (k > 1) @(negedge clk);
         #1;
         if (ready_o === 1'b1) begin
            lat = k;
            res = result_o;
            done_stall = stall_o;
            break;
         end
         nstall += int'(stall_o);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; start_i = 1'b0; signed_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
      annul_i = 1'b0; stall_ext_i = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({result_o, ready_o, stall_o} !== 66'd0)
         $display("FAIL reset_outputs: got result=%h ready=%b stall=%b, want all 0", result_o, ready_o, stall_o);
      else passed++;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_divu_basic();
      logic [63:0] res; int lat, ns; logic ds;
      run_div(32'd100, 32'd7, 1'b0, res, lat, ns, ds);
      checks++;
      if (lat !== 33) $display("FAIL divu_latency: got %0d, want 33", lat); else passed++;
      checks++;
      if (ns !== 33) $display("FAIL divu_stall_cycles: got %0d, want 33", ns); else passed++;
      checks++;
      if (ds !== 1'b0) $display("FAIL divu_stall_in_done: got %b, want 0", ds); else passed++;
      checks++;
      if (res !== {32'd2, 32'd14}) $display("FAIL divu_100_7: got %h, want %h", res, {32'd2, 32'd14});
      else passed++;
   endtask

   task automatic test_signs();
      logic [63:0] res; int lat, ns; logic ds;
      run_div(32'hFFFF_FFF9, 32'd2, 1'b1, res, lat, ns, ds);
      checks++;
      if (res !== 64'hFFFF_FFFF_FFFF_FFFD) $display("FAIL div_m7_2: got %h, want FFFFFFFFFFFFFFFD", res);
      else passed++;
      run_div(32'd7, 32'hFFFF_FFFE, 1'b1, res, lat, ns, ds);
      checks++;
      if (res !== 64'h0000_0001_FFFF_FFFD) $display("FAIL div_7_m2: got %h, want 00000001FFFFFFFD", res);
      else passed++;
   endtask

   task automatic test_overflow();
      logic [63:0] res; int lat, ns; logic ds;
      run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, res, lat, ns, ds);
      checks++;
      if (res !== 64'h0000_0000_8000_0000) $display("FAIL div_intmin_m1: got %h, want 0000000080000000", res);
      else passed++;
      run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, res, lat, ns, ds);
      checks++;
      if (res !== 64'h8000_0000_0000_0000) $display("FAIL divu_80_ff: got %h, want 8000000000000000", res);
      else passed++;
   endtask

   task automatic test_div_zero();
      logic [63:0] res; int lat, ns; logic ds;
      run_div(32'd5, 32'd0, 1'b0, res, lat, ns, ds);
      checks++;
      if (lat !== 1) $display("FAIL divzero_latency: got %0d, want 1", lat); else passed++;
      checks++;
      if (ns !== 1 || ds !== 1'b0) $display("FAIL divzero_stall: got cycles=%0d done=%b, want 1 and 0", ns, ds);
      else passed++;
      checks++;
      if (res !== {32'd5, 32'hFFFF_FFFF}) $display("FAIL divzero_result: got %h, want 00000005FFFFFFFF", res);
      else passed++;
   endtask

   task automatic test_annul();
      int seen;
      // annul in the request cycle must block the start
      @(negedge clk);
      start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd3; annul_i = 1'b1;
      #1;
      checks++;
      if (stall_o !== 1'b0) $display("FAIL annul_idle_stall: got %b, want 0", stall_o); else passed++;
      @(negedge clk);
      start_i = 1'b0; annul_i = 1'b0;
      #1;
      checks++;
      if (stall_o !== 1'b0 || ready_o !== 1'b0)
         $display("FAIL annul_idle_nostart: got stall=%b ready=%b, want 0 0", stall_o, ready_o);
      else passed++;
      // annul in BUSY cycle 10
      @(negedge clk);
      start_i = 1'b1; opdata1_i = 32'd1000; opdata2_i = 32'd9;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         start_i = 1'b0;
      end
      annul_i = 1'b1;
      #1;
      checks++;
      if (stall_o !== 1'b0) $display("FAIL annul_busy_stall: got %b, want 0", stall_o); else passed++;
      @(negedge clk);
      annul_i = 1'b0;
      #1;
      checks++;
      if (stall_o !== 1'b0) $display("FAIL annul_next_idle: got stall=%b, want 0", stall_o); else passed++;
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         #1;
         if (ready_o === 1'b1 || stall_o === 1'b1) seen++;
      end
      checks++;
      if (seen !== 0) $display("FAIL annul_no_result: got %0d active cycles, want 0", seen); else passed++;
   endtask

   task automatic test_reset_mid_busy();
      @(negedge clk);
      start_i = 1'b1; signed_i = 1'b1; opdata1_i = 32'd12345; opdata2_i = 32'd17;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         start_i = 1'b0;
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({result_o, ready_o, stall_o} !== 66'd0)
         $display("FAIL reset_mid_busy: got result=%h ready=%b stall=%b, want all 0", result_o, ready_o, stall_o);
      else passed++;
      @(negedge clk);
      rst = 1'b1;
      repeat (40) @(negedge clk);
      #1;
      checks++;
      if (ready_o !== 1'b0) $display("FAIL reset_no_late_ready: got %b, want 0", ready_o); else passed++;
   endtask

   task automatic test_stall_ext();
      logic [63:0] res; int lat, ns; logic ds; int held;
      run_div(32'd999, 32'd10, 1'b0, res, lat, ns, ds);
      stall_ext_i = 1'b1;
      held = 1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         // a new request while DONE must be ignored
         start_i = (k == 1); opdata1_i = 32'd1; opdata2_i = 32'd1;
         if (k == 3) stall_ext_i = 1'b0;
         #1;
         if (ready_o === 1'b1 && result_o === {32'd9, 32'd99} && stall_o === 1'b0) held++;
      end
      start_i = 1'b0;
      checks++;
      if (held !== 4) $display("FAIL stall_ext_hold: got %0d held cycles, want 4", held); else passed++;
      @(negedge clk);
      #1;
      checks++;
      if (ready_o !== 1'b0 || result_o !== {32'd9, 32'd99})
         $display("FAIL stall_ext_exit: got ready=%b result=%h, want 0 and %h", ready_o, result_o, {32'd9, 32'd99});
      else passed++;
   endtask

   task automatic test_back_to_back();
      logic [63:0] res; int lat, ns; logic ds;
      run_div(32'd81, 32'd9, 1'b0, res, lat, ns, ds);
      run_div(32'hFFFF_FF9C, 32'd7, 1'b1, res, lat, ns, ds);
      checks++;
      if (lat !== 33 || res !== ref_div(32'hFFFF_FF9C, 32'd7, 1'b1))
         $display("FAIL back_to_back: got lat=%0d result=%h, want 33 and %h", lat, res,
                  ref_div(32'hFFFF_FF9C, 32'd7, 1'b1));
      else passed++;
   endtask

   task automatic test_random();
      logic [63:0] res; int lat, ns; logic ds;
      logic [31:0] a, b; logic s;
      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         case ($urandom_range(0, 4))
            0: b = 32'($urandom_range(1, 20));
            1: b = 32'd0;
            2: b = -32'($urandom_range(1, 20));
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
         s = 1'($urandom_range(0, 1));
         run_div(a, b, s, res, lat, ns, ds);
         checks++;
         if (res !== ref_div(a, b, s) || lat !== ((b == 32'd0) ? 1 : 33))
            $display("FAIL random_%0d: a=%h b=%h signed=%b got lat=%0d result=%h, want %h", i, a, b, s,
                     lat, res, ref_div(a, b, s));
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_divu_basic();
      test_signs();
      test_overflow();
      test_div_zero();
      test_annul();
      test_reset_mid_busy();
      test_stall_ext();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule : tb_div_iter
